// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg
//   Shared constants and types for the SPI bridge command path.
//   TX_WORD_W     : TX FIFO command word width.
//   MAX_BURST_DEF : default number of words per grant before forced release.
//   arb_state_e   : TX arbiter FSM state (IDLE, LOCKED).
//   id_w()        : width of a requester index, never below 1 bit.
package spi_bridge_pkg;

    localparam int TX_WORD_W     = 41;
    localparam int MAX_BURST_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// spi_tx_arbiter_if
//   Bundles the requester-side handshake and the TX FIFO write port.
//   req_valid/req_data/req_last : per-requester command words (from requesters)
//   req_ready                   : per-requester word accepted this cycle
//   TxFIFO_wr_en/DATA_to_TxFIFO : TX FIFO write strobe and word
//   TxFIFO_full                 : TX FIFO full flag
//   grant_id/busy               : current owner and grant-held flag
//   Modports: slave = arbiter view, master = requester/FIFO side view.
interface spi_tx_arbiter_if
    import spi_bridge_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = TX_WORD_W
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           TxFIFO_wr_en;
    logic [DATA_W-1:0]              DATA_to_TxFIFO;
    logic                           TxFIFO_full;
    logic [ID_W-1:0]                grant_id;
    logic                           busy;

    modport slave (
        input  req_valid, req_data, req_last, TxFIFO_full,
        output req_ready, TxFIFO_wr_en, DATA_to_TxFIFO, grant_id, busy
    );

    modport master (
        output req_valid, req_data, req_last, TxFIFO_full,
        input  req_ready, TxFIFO_wr_en, DATA_to_TxFIFO, grant_id, busy
    );

endinterface

// File: rtl/spi_tx_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority encoder. Searches req starting at
//   ptr+1 (wrapping modulo N) and returns the first set index.
//   req   : request vector
//   ptr   : last served index (lowest priority)
//   idx   : winning index (0 when nothing found)
//   found : at least one request was set
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = c[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
//   Shares the TX FIFO write port among NUM_REQ command requesters. A grant
//   is won by round-robin in IDLE and held (LOCKED) until the owner's last
//   word or MAX_BURST words, followed by one IDLE cycle. Data passes straight
//   through from the owner to the FIFO with no added latency.
//   HCLK   : clock (rising edge)
//   HRESET : synchronous active-high reset; also masks all outputs while high
//   bus    : spi_tx_arbiter_if.slave (requester handshakes + FIFO write port)
module spi_tx_arbiter
    import spi_bridge_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = TX_WORD_W,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              HCLK,
    input  logic              HRESET,
    spi_tx_arbiter_if.slave   bus
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q,  state_d;
    logic [ID_W-1:0]  grant_q,  grant_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_q,  burst_d;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic              locked;
    logic              xfer;
    logic              release_now;
    logic [DATA_W-1:0] wr_data;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Outputs are gated by HRESET so a reset arriving mid-packet produces no
    // write in the reset cycle itself.
    always_comb begin
        locked      = (state_q == LOCKED) && !HRESET;
        xfer        = locked && !bus.TxFIFO_full && bus.req_valid[grant_q];
        release_now = xfer && (bus.req_last[grant_q] ||
                               (burst_q == CNT_W'(MAX_BURST - 1)));
        wr_data     = xfer ? bus.req_data[grant_q] : '0;

        bus.req_ready = '0;
        if (locked && !bus.TxFIFO_full) begin
            bus.req_ready[grant_q] = 1'b1;
        end
        bus.TxFIFO_wr_en   = xfer;
        bus.DATA_to_TxFIFO = wr_data;
        bus.busy           = locked;
        bus.grant_id       = HRESET ? '0 : grant_q;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = pick_idx;
                    burst_d = '0;
                end
            end
            LOCKED: begin
                // A dropped req_valid just stalls here; only a transfer can
                // end the grant. last on the MAX_BURST-th word is one release.
                if (xfer) begin
                    burst_d = burst_q + 1'b1;
                end
                if (release_now) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter
//   Directed bench for spi_tx_arbiter. Each requester is a small packet
//   source (word count, index of the word carrying last, optional stall);
//   word n of requester r carries data r*256+n. Every FIFO write is logged
//   with its cycle and grant_id and compared against hand-derived tables.
module tb_spi_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 41;

    logic HCLK;
    logic HRESET;

    spi_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus_if ();

    spi_tx_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (8)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus_if)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_chk;
    int n_bad;
    int cyc;
    int base;

    int words_left [NR];
    int sent       [NR];
    int last_at    [NR];
    bit stall      [NR];
    bit full_in;

    logic          s_wr;
    logic [DW-1:0] s_data;
    logic [NR-1:0] s_rdy;
    logic          s_busy;
    logic [1:0]    s_gnt;

    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    int            wr_gnt_q  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc - base);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus_if.req_valid[i] = (words_left[i] > 0) && !stall[i];
            bus_if.req_data[i]  = DW'(i * 256 + sent[i] + 1);
            bus_if.req_last[i]  = (last_at[i] != 0) && (sent[i] + 1 == last_at[i]);
        end
        bus_if.TxFIFO_full = full_in;
    endtask

    // One clock: apply inputs, sample outputs on the falling edge, advance the
    // requester model on accepted words, then step past the rising edge.
    task automatic cycle();
        drive();
        @(negedge HCLK);
        s_wr   = bus_if.TxFIFO_wr_en;
        s_data = bus_if.DATA_to_TxFIFO;
        s_rdy  = bus_if.req_ready;
        s_busy = bus_if.busy;
        s_gnt  = bus_if.grant_id;
        if (s_wr) begin
            wr_data_q.push_back(s_data);
            wr_cyc_q.push_back(cyc);
            wr_gnt_q.push_back(int'(s_gnt));
        end
        if (full_in) begin
            check("full_wr_en", s_wr, 1'b0);
            check("full_ready", s_rdy, '0);
        end
        for (int i = 0; i < NR; i++) begin
            if (bus_if.req_valid[i] && s_rdy[i]) begin
                sent[i]++;
                words_left[i]--;
            end
        end
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input int r, input int n, input int last);
        words_left[r] = n;
        sent[r]       = 0;
        last_at[r]    = last;
    endtask

    task automatic reset_dut();
        for (int i = 0; i < NR; i++) begin
            load(i, 0, 0);
            stall[i] = 1'b0;
        end
        full_in = 1'b0;
        HRESET  = 1'b1;
        cycle();
        HRESET  = 1'b0;
        wr_data_q.delete();
        wr_cyc_q.delete();
        wr_gnt_q.delete();
        base = cyc;
    endtask

    task automatic expect_wr(input string tag, input int k, input int data,
                             input int rel_cyc, input int gnt);
        if (k < wr_data_q.size()) begin
            check({tag, "_data"}, wr_data_q[k], 64'(data));
            check({tag, "_cycle"}, 64'(wr_cyc_q[k] - base), 64'(rel_cyc));
            check({tag, "_grant"}, 64'(wr_gnt_q[k]), 64'(gnt));
        end else begin
            check({tag, "_missing"}, 64'(wr_data_q.size()), 64'(k + 1));
        end
    endtask

    typedef struct {
        int data;
        int cyc;
        int gnt;
    } wr_exp_t;

    wr_exp_t exp3 [14];

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        cyc     = 0;
        base    = 0;
        full_in = 1'b0;
        for (int i = 0; i < NR; i++) begin
            stall[i] = 1'b0;
            load(i, 1, 1);
        end

        // Reset with every requester valid: all outputs held at reset values.
        HRESET = 1'b1;
        run(2);
        check("rst_busy", s_busy, 1'b0);
        check("rst_wr_en", s_wr, 1'b0);
        check("rst_ready", s_rdy, '0);
        check("rst_grant", s_gnt, '0);
        check("rst_data", s_data, '0);

        // Four single-word packets: order 0,1,2,3 with one idle cycle between.
        reset_dut();
        for (int i = 0; i < NR; i++) load(i, 1, 1);
        run(10);
        check("rr_count", 64'(wr_data_q.size()), 64'd4);
        expect_wr("rr0", 0, 'h001, 1, 0);
        expect_wr("rr1", 1, 'h101, 3, 1);
        expect_wr("rr2", 2, 'h201, 5, 2);
        expect_wr("rr3", 3, 'h301, 7, 3);

        // Requester 2 owns a 3-word packet while requester 1 waits.
        reset_dut();
        load(2, 3, 3);
        cycle();
        load(1, 1, 1);
        run(8);
        check("pkt_count", 64'(wr_data_q.size()), 64'd4);
        expect_wr("pkt_w1", 0, 'h201, 1, 2);
        expect_wr("pkt_w2", 1, 'h202, 2, 2);
        expect_wr("pkt_w3", 2, 'h203, 3, 2);
        expect_wr("pkt_r1", 3, 'h101, 5, 1);

        // Requester 0 streams 12 words (last only on 12): forced release after 8,
        // then 1 and 3 are served before 0 resumes with words 9-12.
        reset_dut();
        load(0, 12, 12);
        load(1, 1, 1);
        load(3, 1, 1);
        run(20);
        for (int k = 0; k < 8; k++) exp3[k] = '{k + 1, k + 1, 0};
        exp3[8] = '{'h101, 10, 1};
        exp3[9] = '{'h301, 12, 3};
        for (int k = 10; k < 14; k++) exp3[k] = '{k - 1, k + 4, 0};
        check("burst_count", 64'(wr_data_q.size()), 64'd14);
        for (int k = 0; k < 14; k++) begin
            expect_wr($sformatf("burst_%0d", k), k, exp3[k].data, exp3[k].cyc, exp3[k].gnt);
        end

        // FIFO full for 5 cycles in the middle of a 6-word packet.
        reset_dut();
        load(1, 6, 6);
        for (int k = 0; k < 14; k++) begin
            full_in = (k >= 3) && (k <= 7);
            cycle();
            if (k >= 3 && k <= 7) begin
                check("full_busy", s_busy, 1'b1);
                check("full_grant", s_gnt, 2'd1);
            end
        end
        full_in = 1'b0;
        check("full_count", 64'(wr_data_q.size()), 64'd6);
        expect_wr("full_w1", 0, 'h101, 1, 1);
        expect_wr("full_w2", 1, 'h102, 2, 1);
        expect_wr("full_w3", 2, 'h103, 8, 1);
        expect_wr("full_w4", 3, 'h104, 9, 1);
        expect_wr("full_w5", 4, 'h105, 10, 1);
        expect_wr("full_w6", 5, 'h106, 11, 1);

        // Reset pulsed during word 2 of requester 1's 4-word packet.
        reset_dut();
        load(1, 4, 4);
        cycle();
        load(0, 1, 1);
        cycle();
        HRESET = 1'b1;
        cycle();
        check("mid_rst_wr_en", s_wr, 1'b0);
        check("mid_rst_ready", s_rdy, '0);
        check("mid_rst_busy", s_busy, 1'b0);
        check("mid_rst_grant", s_gnt, '0);
        check("mid_rst_data", s_data, '0);
        HRESET = 1'b0;
        cycle();
        check("post_rst_busy", s_busy, 1'b0);
        check("post_rst_wr_en", s_wr, 1'b0);
        run(4);
        expect_wr("mid_rst_w1", 0, 'h101, 1, 1);
        expect_wr("mid_rst_r0", 1, 'h001, 4, 0);
        expect_wr("mid_rst_r1", 2, 'h102, 6, 1);

        // Owner 3 drops req_valid for 3 cycles while 0 and 1 are valid.
        reset_dut();
        load(3, 4, 4);
        cycle();
        load(0, 1, 1);
        load(1, 1, 1);
        run(2);
        stall[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_busy", s_busy, 1'b1);
            check("stall_grant", s_gnt, 2'd3);
            check("stall_wr_en", s_wr, 1'b0);
        end
        stall[3] = 1'b0;
        run(10);
        check("stall_count", 64'(wr_data_q.size()), 64'd6);
        expect_wr("stall_w1", 0, 'h301, 1, 3);
        expect_wr("stall_w2", 1, 'h302, 2, 3);
        expect_wr("stall_w3", 2, 'h303, 6, 3);
        expect_wr("stall_w4", 3, 'h304, 7, 3);
        expect_wr("stall_r0", 4, 'h001, 9, 0);
        expect_wr("stall_r1", 5, 'h101, 11, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of command requesters sharing the TX FIFO write port.
REQ-002 Parameter DATA_W, default 41: TX FIFO command word width.
REQ-003 Parameter MAX_BURST, default 8: maximum words per grant before a forced release.
REQ-004 Port HCLK  input  1: sole clock; all logic is on its rising edge.
REQ-005 Port HRESET  input  1: synchronous, active-high reset.
REQ-006 Port req_valid  input  NUM_REQ: per-requester word-valid.
REQ-007 Port req_data  input  NUM_REQ x DATA_W: per-requester command word.
REQ-008 Port req_last  input  NUM_REQ: marks the final word of the requester's packet.
REQ-009 Port req_ready  output  NUM_REQ: per-requester word accepted this cycle.
REQ-010 Port TxFIFO_wr_en  output  1: TX FIFO write strobe.
REQ-011 Port DATA_to_TxFIFO  output  DATA_W: word written into the TX FIFO.
REQ-012 Port TxFIFO_full  input  1: TX FIFO full flag.
REQ-013 Port grant_id  output  clog2(NUM_REQ): index of the current owner, valid while busy=1.
REQ-014 Port busy  output  1: a requester holds the grant.

Function
REQ-015 The FSM SHALL have two states: IDLE and LOCKED.
REQ-016 In IDLE with any req_valid set, the block SHALL register the winner by round-robin search starting at rr_ptr+1 (modulo NUM_REQ), then enter LOCKED next cycle; arbitration latency is exactly 1 cycle.
REQ-017 In IDLE, req_ready SHALL be all-zero and TxFIFO_wr_en SHALL be 0.
REQ-018 In LOCKED, req_ready[grant_id] SHALL equal !TxFIFO_full combinationally; every other req_ready bit SHALL be 0.
REQ-019 A transfer occurs when req_valid[g] && req_ready[g]; in that cycle TxFIFO_wr_en SHALL be 1 and DATA_to_TxFIFO SHALL equal req_data[g], with zero added latency.
REQ-020 TxFIFO_wr_en SHALL never assert while TxFIFO_full=1.
REQ-021 The owner deasserting req_valid mid-packet SHALL NOT release the grant; the block waits.
REQ-022 burst_cnt SHALL count transfers in LOCKED, reset to 0 on entry to LOCKED, and have width clog2(MAX_BURST+1).
REQ-023 A transfer with req_last=1, or the transfer that brings burst_cnt to MAX_BURST, SHALL return the FSM to IDLE on the next edge.
REQ-024 On release, rr_ptr SHALL load grant_id, so the just-served requester has lowest priority next.
REQ-025 req_last on the MAX_BURST-th word SHALL be treated as a single release, with no double pointer update.
REQ-026 A requester SHALL hold req_data and req_last stable while req_valid=1 and req_ready=0; the arbiter relies on this and does not latch the data.
REQ-027 There SHALL be one IDLE cycle between consecutive grants, including back-to-back requests from the same requester.

Reset
REQ-028 HRESET=1 SHALL force: state IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority), burst_cnt=0, grant_id=0, busy=0, req_ready=0, TxFIFO_wr_en=0, DATA_to_TxFIFO=0.
REQ-029 HRESET asserted mid-packet SHALL abandon the packet with no write in the reset cycle; no partial-packet recovery is performed.

Structure
REQ-030 A shared package spi_bridge_pkg SHALL hold TX_WORD_W=41, the arbiter state enum (IDLE, LOCKED), and the default MAX_BURST constant.
REQ-031 A single sub-module rr_pick (combinational round-robin priority encoder: request vector plus pointer in, index and found flag out) SHALL be used; all sequential logic stays in spi_tx_arbiter.

Verification
REQ-032 After reset, req_valid=4'b1111 with each requester sending 1 word (last=1) -> grant order 0,1,2,3, with 1 idle cycle between writes.
REQ-033 Requester 2 sends 3 words with last on word 3 while requester 1 is valid -> three consecutive writes from 2 with no interleaving; 1 is granted on cycle 5.
REQ-034 Requester 0 sends 12 words with no last, MAX_BURST=8 -> release after 8 writes; other valid requesters are served before 0 resumes with words 9-12.
REQ-035 TxFIFO_full=1 for 5 cycles mid-burst -> req_ready=0 and TxFIFO_wr_en=0 throughout; data is held; no word is lost or duplicated after full clears.
REQ-036 HRESET pulsed during the word-2 transfer of a 4-word packet -> outputs return to reset values next edge; the next grant goes to requester 0 if valid.
REQ-037 Owner drops req_valid for 3 cycles mid-packet while others are valid -> grant_id unchanged and busy=1 until the owner's last word.
